dmem_access_ctrl: RTL and testbench

CPU-side initiator for the 8-bit data memory's `read`/`write`/`busy_wait` handshake. It sits between the control unit and the data memory. It accepts one load or store request at a time and drives stable memory strobes, address and write data. While the memory holds busy, it stalls the processor. On completion it delivers load data to the register file as a single-cycle write, and a watchdog aborts any access whose busy never clears.

---
 rtl/dmem_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// CPU-side initiator for the data memory read/write/busy_wait handshake.
// Holds one load/store at a time, stalls the core while busy, and aborts hung accesses.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 200,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_rd,
  output logic              req_ready,
  output logic              stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [2:0]        rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic              err
);

  // state  | meaning
  // IDLE   | no access in flight, waiting for a request
  // ACCESS | strobes high, sampling mem_busy each edge, watchdog counting
  // RESP   | one-cycle done/err pulse; load data presented to the register file
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        rd_q, rd_d;
  logic              we_q, we_d;
  logic              rd_stb_q, rd_stb_d;
  logic              wr_stb_q, wr_stb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              accept;

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      rd_stb_q <= 1'b0;
      wr_stb_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      rd_stb_q <= rd_stb_d;
      wr_stb_q <= wr_stb_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    we_d     = we_q;
    rd_stb_d = rd_stb_q;
    wr_stb_d = wr_stb_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) accept = 1'b1;
      end
      S_ACCESS: begin
        if (!mem_busy) begin
          if (!we_q) rdata_d = mem_rdata;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
          state_d  = S_RESP;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_C) begin
            rd_stb_d = 1'b0;
            wr_stb_d = 1'b0;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_RESP: begin
        // A request held through the stall is taken on the edge that ends RESP,
        // giving back-to-back accesses without an idle bubble.
        if (req_valid) accept = 1'b1;
        else           state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      addr_d   = req_addr;
      wdata_d  = req_wdata;
      rd_d     = req_rd;
      we_d     = req_we;
      wr_stb_d = req_we;
      rd_stb_d = !req_we;
      rdata_d  = '0;
      err_d    = 1'b0;
      cnt_d    = '0;
      state_d  = S_ACCESS;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign stall     = (state_q == S_ACCESS) || (state_q == S_RESP);
  assign mem_read  = rd_stb_q;
  assign mem_write = wr_stb_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == S_RESP);
  assign err       = (state_q == S_RESP) && err_q;
  assign rf_we     = (state_q == S_RESP) && !we_q && !err_q;
  assign rf_addr   = rd_q;
  assign rf_wdata  = rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table vectors, hand-written reset
// sequences, and random traffic against a behavioural memory/timing model.
module tb_dmem_access_ctrl;

  localparam int TO = 200;

  logic       clk, rst;
  logic       req_valid, req_we;
  logic [7:0] req_addr, req_wdata;
  logic [2:0] req_rd;
  logic       req_ready, stall, mem_read, mem_write;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_busy;
  logic [7:0] mem_rdata;
  logic       rf_we;
  logic [2:0] rf_addr;
  logic [7:0] rf_wdata;
  logic       done, err;

  dmem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .req_ready(req_ready),
    .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_busy(mem_busy),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_wdata(rf_wdata), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_mem [256];
  logic [7:0] ref_mem   [256];
  int         busy_k = 0;
  bit         stuck  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] outv();
    return {req_ready, stall, mem_read, mem_write, done, err, rf_we};
  endfunction

  // Behavioural memory: busy for busy_k sampled edges after the strobe rises.
  initial begin
    bit active = 1'b0;
    int rem = 0;
    mem_busy  = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (mem_read || mem_write) begin
        if (!active) begin
          active = 1'b1;
          rem = busy_k;
        end else begin
          rem--;
        end
        mem_busy = stuck || (rem > 0);
        if (!mem_busy) begin
          if (mem_write) model_mem[mem_addr] = mem_wdata;
          mem_rdata = model_mem[mem_addr];
        end else begin
          mem_rdata = 8'($urandom);
        end
      end else begin
        active    = 1'b0;
        mem_busy  = 1'b0;
        mem_rdata = 8'($urandom);
      end
    end
  end

  // Called at posedge+2 with the DUT in IDLE or RESP; returns at posedge+2 in RESP.
  task automatic run_txn(input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [2:0] rd, input int k, input bit stk, input bit ign,
                         input int exp_c, input bit exp_err, input logic [7:0] exp_rdata,
                         input bit exp_rfwe);
    logic [6:0] ev;
    busy_k    = k;
    stuck     = stk;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    for (int n = 0; n <= exp_c; n++) begin
      @(posedge clk);
      #2;
      ev = {1'b0, 1'b1, (n < exp_c) && !we, (n < exp_c) && we, n == exp_c,
            (n == exp_c) && exp_err, (n == exp_c) && exp_rfwe};
      chk("ctrl_vec", 32'(outv()), 32'(ev));
      chk("mem_addr", 32'(mem_addr), 32'(addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(wdata));
      if (n == exp_c) begin
        req_valid = 1'b0;
        chk("rf_addr", 32'(rf_addr), 32'(rd));
        if (!we) chk("rf_wdata", 32'(rf_wdata), 32'(exp_rdata));
      end else begin
        req_valid = ign ? 1'($urandom) : 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = 8'($urandom);
        req_rd    = 3'($urandom);
      end
    end
    stuck = 1'b0;
  endtask

  task automatic idle_check();
    @(posedge clk);
    #2;
    chk("idle_vec", 32'(outv()), 32'(7'b1000000));
  endtask

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [2:0] rd;
    int         k;
    bit         stk;
    bit         ign;
    bit         chain;
    int         exp_c;
    bit         exp_err;
    logic [7:0] exp_rdata;
    bit         exp_rfwe;
  } vec_t;

  vec_t tbl [8];

  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i * 3 + 1);
      ref_mem[i]   = 8'((i << 1) + i + 1);
    end

    tbl[0] = '{1'b1, 8'd25, 8'd45, 3'd0, 100, 1'b0, 1'b0, 1'b0, 101, 1'b0, 8'd0,  1'b0};
    tbl[1] = '{1'b0, 8'd25, 8'd0,  3'd7, 100, 1'b0, 1'b0, 1'b0, 101, 1'b0, 8'd45, 1'b1};
    tbl[2] = '{1'b1, 8'd16, 8'd65, 3'd0, 0,   1'b0, 1'b0, 1'b0, 1,   1'b0, 8'd0,  1'b0};
    tbl[3] = '{1'b0, 8'd16, 8'd0,  3'd2, 0,   1'b0, 1'b1, 1'b1, 1,   1'b0, 8'd65, 1'b1};
    tbl[4] = '{1'b0, 8'd25, 8'd0,  3'd5, 0,   1'b0, 1'b1, 1'b0, 1,   1'b0, 8'd45, 1'b1};
    tbl[5] = '{1'b0, 8'd40, 8'd0,  3'd3, 0,   1'b1, 1'b1, 1'b0, TO,  1'b1, 8'd0,  1'b0};
    tbl[6] = '{1'b1, 8'd40, 8'h3C, 3'd0, 2,   1'b0, 1'b0, 1'b0, 3,   1'b0, 8'd0,  1'b0};
    tbl[7] = '{1'b0, 8'd40, 8'd0,  3'd1, 1,   1'b0, 1'b0, 1'b0, 2,   1'b0, 8'h3C, 1'b1};

    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'd0; req_wdata = 8'd0; req_rd = 3'd0;

    // Reset asserted between edges must take effect with no clock.
    #3 rst = 1'b1;
    #1;
    chk("reset_vec", 32'(outv()), 32'(7'b1000000));
    chk("reset_addr", 32'({mem_addr, mem_wdata, rf_wdata, 5'b0, rf_addr}), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].k, tbl[i].stk,
              tbl[i].ign, tbl[i].exp_c, tbl[i].exp_err, tbl[i].exp_rdata, tbl[i].exp_rfwe);
      if (tbl[i].we && !tbl[i].exp_err) ref_mem[tbl[i].addr] = tbl[i].wdata;
      if (i == 0) chk("mem25_after_store", 32'(model_mem[25]), 32'd45);
      if (!tbl[i].chain) idle_check();
    end

    // Reset in the middle of a long store: strobes drop at once, no completion.
    busy_k = 100;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd77; req_wdata = 8'h99; req_rd = 3'd0;
    @(posedge clk);
    #2 req_valid = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    chk("pre_rst_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vec", 32'(outv()), 32'(7'b1000000));
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #2;
      chk("post_rst_vec", 32'(outv()), 32'(7'b1000000));
    end
    chk("aborted_store_dropped", 32'(model_mem[77]), 32'(ref_mem[77]));
    run_txn(1'b0, 8'd77, 8'd0, 3'd6, 3, 1'b0, 1'b0, 4, 1'b0, ref_mem[77], 1'b1);
    idle_check();

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit         we;
      logic [7:0] addr, wdata, erd;
      logic [2:0] rd;
      int         k, c;
      bit         e, chain;
      we    = 1'($urandom);
      addr  = 8'($urandom_range(0, 7));
      wdata = 8'($urandom);
      rd    = 3'($urandom);
      k     = int'($urandom_range(0, 4));
      chain = (i != 39) && 1'($urandom);
      e     = (TO != 0) && (k >= TO);
      c     = e ? TO : k + 1;
      erd   = (we || e) ? 8'd0 : ref_mem[addr];
      run_txn(we, addr, wdata, rd, k, 1'b0, 1'($urandom), c, e, erd, !we && !e);
      if (we && !e) ref_mem[addr] = wdata;
      if (!chain) idle_check();
    end

    for (int i = 0; i < 8; i++)
      chk("final_mem", 32'(model_mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
